// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants, feeder FSM state and block word-reversal helper
package sha256_pkg;
  localparam logic [383:0] SHA256_PAD_640 = {32'h8000_0000, 320'h0, 32'h0000_0280};
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic logic [511:0] word_reverse(input logic [511:0] raw);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = raw[511-32*i -: 32];
    return r;
  endfunction
endpackage

// File: rtl/sha256_block_builder.sv
// sha256_block_builder: combinational padded, word-reversed second block from header tail + nonce
//   tail  in  96   header bytes 64..75, big-endian
//   nonce in  32   nonce to embed
//   block out 512  data1 layout expected by sha256_double
module sha256_block_builder
  import sha256_pkg::*;
(
  input  logic [95:0]  tail,
  input  logic [31:0]  nonce,
  output logic [511:0] block
);
  assign block = word_reverse({tail, nonce, SHA256_PAD_640});
endmodule

// File: rtl/sha256_work_feeder.sv
// sha256_work_feeder: accepts one mining work item and streams one nonce block per cycle to sha256_double
//   clk, reset (sync, active-high)
//   work_valid/work_ready, work_midstate, work_tail, work_nonce_start, work_nonce_count: work handshake
//   hash0, data1, data_valid, nonce_out: registered block stream to sha256_double
//   busy: job in progress; done: one-cycle pulse once the last hash has left the pipeline
//   Optional SHA256_FEEDER_ABORT_EN: abort input, aborted output (high with done on aborted jobs)
module sha256_work_feeder
  import sha256_pkg::*;
#(
  parameter int          PIPE_LATENCY = 128,
  parameter logic [31:0] NONCE_STEP   = 32'd1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [255:0] work_midstate,
  input  logic [95:0]  work_tail,
  input  logic [31:0]  work_nonce_start,
  input  logic [31:0]  work_nonce_count,
  output logic [255:0] hash0,
  output logic [511:0] data1,
  output logic         data_valid,
  output logic [31:0]  nonce_out,
  output logic         busy,
  output logic         done
`ifdef SHA256_FEEDER_ABORT_EN
  ,
  input  logic         abort,
  output logic         aborted
`endif
);
  localparam int DW = $clog2(PIPE_LATENCY + 1);
  state_t state, state_next;
  logic [95:0] tail_q;
  logic [32:0] remaining;
  logic [DW-1:0] drain_cnt;
  logic [31:0] build_nonce;
  logic [95:0] build_tail;
  logic [511:0] block;
  logic accept, last, abort_req, stop;
`ifdef SHA256_FEEDER_ABORT_EN
  logic aborted_q;
  assign abort_req = abort;
  assign aborted = done & aborted_q;
`else
  assign abort_req = 1'b0;
`endif
  assign accept = work_valid && work_ready;
  assign last = remaining == 33'd1;
  assign stop = last || abort_req;
  // The builder sees the incoming item on acceptance so the first block is registered on that edge.
  assign build_nonce = accept ? work_nonce_start : nonce_out + NONCE_STEP;
  assign build_tail = accept ? work_tail : tail_q;
  sha256_block_builder u_builder (
    .tail (build_tail),
    .nonce(build_nonce),
    .block(block)
  );
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_comb
    state_next = (state == IDLE) ? (work_valid ? RUN : IDLE)
               : (state == RUN)  ? (stop ? DRAIN : RUN)
               : (drain_cnt == DW'(1)) ? IDLE : DRAIN;
  always_comb begin
    work_ready = state == IDLE;
    busy = state != IDLE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      hash0 <= '0;
      data1 <= '0;
      nonce_out <= '0;
      data_valid <= 1'b0;
      done <= 1'b0;
      tail_q <= '0;
      remaining <= '0;
      drain_cnt <= '0;
`ifdef SHA256_FEEDER_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      done <= state == DRAIN && drain_cnt == DW'(1);
      if (accept) begin
        hash0 <= work_midstate;
        tail_q <= work_tail;
        data1 <= block;
        nonce_out <= work_nonce_start;
        data_valid <= 1'b1;
        remaining <= {work_nonce_count == 32'd0, work_nonce_count};
`ifdef SHA256_FEEDER_ABORT_EN
        aborted_q <= 1'b0;
`endif
      end else if (state == RUN) begin
        if (stop) begin
          data_valid <= 1'b0;
          drain_cnt <= DW'(PIPE_LATENCY);
`ifdef SHA256_FEEDER_ABORT_EN
          aborted_q <= abort_req;
`endif
        end else begin
          data1 <= block;
          nonce_out <= build_nonce;
          remaining <= remaining - 33'd1;
        end
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt - DW'(1);
      end
    end
endmodule

// File: tb/tb_sha256_work_feeder.sv
// tb_sha256_work_feeder: table-driven jobs with a nonce/data1 scoreboard plus reset, count=0 and abort sequences
module tb_sha256_work_feeder;
  localparam int PL = 128;
  logic clk = 1'b0;
  logic reset, work_valid, work_ready, data_valid, busy, done;
  logic [255:0] work_midstate, hash0;
  logic [95:0] work_tail;
  logic [31:0] work_nonce_start, work_nonce_count, nonce_out;
  logic [511:0] data1;
`ifdef SHA256_FEEDER_ABORT_EN
  logic abort, aborted;
  int aborted_seen = 0;
`endif
  always #5 clk = ~clk;
  sha256_work_feeder #(.PIPE_LATENCY(PL), .NONCE_STEP(32'd1)) dut (
    .clk(clk), .reset(reset), .work_valid(work_valid), .work_ready(work_ready),
    .work_midstate(work_midstate), .work_tail(work_tail),
    .work_nonce_start(work_nonce_start), .work_nonce_count(work_nonce_count),
    .hash0(hash0), .data1(data1), .data_valid(data_valid), .nonce_out(nonce_out),
    .busy(busy), .done(done)
`ifdef SHA256_FEEDER_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );
  typedef struct {
    logic [511:0] data1;
    logic [31:0]  nonce;
  } exp_t;
  typedef struct {
    logic [95:0]  tail;
    logic [255:0] mid;
    logic [31:0]  start;
    logic [31:0]  count;
    logic [31:0]  exp_last;
  } job_t;
  exp_t sb[$];
  exp_t e_m;
  job_t jobs[4];
  int checks = 0, errors = 0;
  int cyc = 0, valid_cnt = 0, done_cnt = 0, last_valid_cyc = 0, done_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [511:0] model(input logic [95:0] t, input logic [31:0] n);
    logic [511:0] d = '0;
    d[31:0] = t[95:64];
    d[63:32] = t[63:32];
    d[95:64] = t[31:0];
    d[127:96] = n;
    d[159:128] = 32'h8000_0000;
    d[511:480] = 32'h0000_0280;
    return d;
  endfunction
  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (data_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: nonce_out %0h with empty scoreboard", nonce_out);
      end else begin
        e_m = sb.pop_front();
        check("nonce_out", nonce_out, e_m.nonce);
        check("data1", data1, e_m.data1);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
`ifdef SHA256_FEEDER_ABORT_EN
      if (aborted) aborted_seen++;
`endif
    end
  end
  task automatic push_exp(input logic [95:0] t, input logic [31:0] start, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.nonce = start + 32'(k);
      e.data1 = model(t, e.nonce);
      sb.push_back(e);
    end
  endtask
  task automatic offer(input logic [95:0] t, input logic [255:0] m, input logic [31:0] s, input logic [31:0] c);
    work_tail = t;
    work_midstate = m;
    work_nonce_start = s;
    work_nonce_count = c;
    work_valid = 1'b1;
    @(posedge clk);
    #1 work_valid = 1'b0;
    check("hash0_latch", 512'(hash0), 512'(m));
  endtask
  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      #1 n++;
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask
  initial begin
    int v0, d0;
    reset = 1'b1;
    work_valid = 1'b0;
    work_tail = '0;
    work_midstate = '0;
    work_nonce_start = '0;
    work_nonce_count = '0;
`ifdef SHA256_FEEDER_ABORT_EN
    abort = 1'b0;
`endif
    jobs[0] = '{96'hDEAD_BEEF_0000_1111_2222_3333, {8{32'h1111_0000}}, 32'h0000_0010, 32'd4, 32'h0000_0013};
    jobs[1] = '{96'h0102_0304_0506_0708_090A_0B0C, {8{32'h2222_5555}}, 32'hAABB_CCDD, 32'd1, 32'hAABB_CCDD};
    jobs[2] = '{96'hCAFE_F00D_1234_5678_9ABC_DEF0, {8{32'h3333_AAAA}}, 32'hFFFF_FFFE, 32'd3, 32'h0000_0000};
    jobs[3] = '{96'h0F0E_0D0C_0B0A_0908_0706_0504, {8{32'h4444_1234}}, 32'h1234_5678, 32'd7, 32'h1234_567E};
    repeat (3) @(posedge clk);
    #1;
    check("rst_hash0", 512'(hash0), 512'h0);
    check("rst_data1", data1, 512'h0);
    check("rst_nonce", 512'(nonce_out), 512'h0);
    check("rst_flags", 512'({data_valid, busy, done, work_ready}), 512'(4'b0001));
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      push_exp(jobs[i].tail, jobs[i].start, int'(jobs[i].count));
      v0 = valid_cnt;
      d0 = done_cnt;
      offer(jobs[i].tail, jobs[i].mid, jobs[i].start, jobs[i].count);
      wait_done(d0, int'(jobs[i].count) + PL + 20);
      check("valid_count", 512'(valid_cnt - v0), 512'(jobs[i].count));
      check("done_latency", 512'(done_cyc - last_valid_cyc), 512'(PL + 1));
      check("last_nonce", 512'(nonce_out), 512'(jobs[i].exp_last));
      check("sb_empty", 512'(sb.size()), 512'h0);
      check("busy_after", 512'({busy, work_ready, data_valid}), 512'(3'b010));
      if (i == 1) begin
        check("d1_nonce_word", 512'(data1[127:96]), 512'(32'hAABB_CCDD));
        check("d1_tail_word", 512'(data1[31:0]), 512'(32'h0102_0304));
        check("d1_pad_word", 512'(data1[159:128]), 512'(32'h8000_0000));
        check("d1_len_word", 512'(data1[511:480]), 512'(32'h0000_0280));
      end
    end
    // count=0 means 2^32: after many blocks the job must still be running
    push_exp(96'h1, 32'hFFFF_FF00, 400);
    v0 = valid_cnt;
    d0 = done_cnt;
    offer(96'h1, 256'h5, 32'hFFFF_FF00, 32'd0);
    for (int n = 0; n < 1000 && valid_cnt - v0 < 300; n++) begin
      @(posedge clk);
      #1;
    end
    check("cnt0_valids", 512'(valid_cnt - v0 >= 300), 512'h1);
    check("cnt0_running", 512'({busy, data_valid, done_cnt == d0}), 512'(3'b111));
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    // reset on the second RUN cycle aborts with no done
    push_exp(96'h7, 32'h100, 10);
    d0 = done_cnt;
    offer(96'h7, 256'h9, 32'h100, 32'd10);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_hash0", 512'(hash0), 512'h0);
    check("rstmid_data1", data1, 512'h0);
    check("rstmid_flags", 512'({data_valid, busy, done, work_ready, nonce_out}), 512'({4'b0001, 32'h0}));
    reset = 1'b0;
    sb.delete();
    repeat (PL + 20) @(posedge clk);
    #1;
    check("rstmid_no_done", 512'(done_cnt - d0), 512'h0);
`ifdef SHA256_FEEDER_ABORT_EN
    push_exp(96'hABC, 32'h500, 10);
    v0 = valid_cnt;
    d0 = done_cnt;
    offer(96'hABC, 256'h77, 32'h500, 32'd10);
    @(posedge clk);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_done(d0, PL + 30);
    check("abort_valids", 512'(valid_cnt - v0), 512'd3);
    check("abort_latency", 512'(done_cyc - last_valid_cyc), 512'(PL + 1));
    check("aborted_seen", 512'(aborted_seen), 512'd1);
    sb.delete();
    push_exp(96'hDEF, 32'h900, 2);
    v0 = valid_cnt;
    d0 = done_cnt;
    offer(96'hDEF, 256'h88, 32'h900, 32'd2);
    wait_done(d0, PL + 30);
    check("abort_next_valids", 512'(valid_cnt - v0), 512'd2);
    check("abort_next_clean", 512'(aborted_seen), 512'd1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
